vpu_ram: RTL and testbench
==========================

# vpu_ram

Dual-port byte memory that answers the VPU's external memory ports. Port A is the read-only instruction/data port and port B is the read/write load-store port. After reset the block sits in a load phase: a host loader streams the program image in through a valid/ready port. It then releases the VPU by raising `mem_ready` and serves port A/B traffic with one-cycle read latency.

## Interface
- `ADDR_WID`, 16, number of implemented address bits; depth is `1 << ADDR_WID`.
- `DATA_WID`, 8, width of one memory word, equal to the VPU's `RAM_DATA_WID` width.

- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `addr_a`  in  32  port A read address.
- `data_a`  out  DATA_WID  port A read data, registered.
- `addr_b`  in  32  port B address.
- `we_b`  in  1  port B write enable.
- `src_b`  in  DATA_WID  port B write data.
- `data_b`  out  DATA_WID  port B read data, registered.
- `ld_valid`  in  1  loader beat valid.
- `ld_ready`  out  1  loader beat accepted when high together with `ld_valid`.
- `ld_addr`  in  ADDR_WID  loader write address.
- `ld_data`  in  DATA_WID  loader write data.
- `ld_last`  in  1  marks the final loader beat.
- `mem_ready`  out  1  memory is in RUN; this is the VPU release signal.
- `addr_err`  out  1  sticky out-of-range access flag.

## Operation
- State machine has two states, LOAD and RUN; reset enters LOAD.
- LOAD state:
  - `ld_ready` = 1; an accepted beat writes `mem[ld_addr] <= ld_data`.
  - An accepted beat with `ld_last` = 1 moves the FSM to RUN at that edge.
  - `ld_valid` with `ld_last` = 0 stays in LOAD.
  - `we_b` is ignored and port A/B reads are not performed; `data_a`/`data_b` hold 0.
- RUN state:
  - `ld_ready` = 0 and loader inputs are ignored.
  - RUN is left only by reset.
- Address decode, applied to ports A and B in RUN:
  - If `addr[31:ADDR_WID]` == 0, the access is in range and indexes `mem[addr[ADDR_WID-1:0]]`.
  - Otherwise it is out of range: the read returns 0, the write is dropped, and `addr_err` <= 1.
  - `addr_err` is sticky until reset.
- Port A: `data_a <= mem[addr_a]` every RUN cycle, with no enable.
- Port B read (`we_b` = 0): `data_b <= mem[addr_b]`.
- Port B write (`we_b` = 1, in range): `mem[addr_b] <= src_b` and `data_b <= src_b` (write-through).
- Collision, port A reading the address port B writes in the same cycle: read-first.
  - `data_a` returns the old contents.
  - The new value is visible on port A from the next access.
- Memory array contents are not reset. Contents survive `rst_in`; only state and outputs clear.
- The reset write path has no data dependency on the ports, so the array maps to block RAM.

## Timing
- Reset values (asynchronous, while `rst_in` = 0):
  - state = LOAD
  - `data_a` = 0, `data_b` = 0
  - `mem_ready` = 0, `addr_err` = 0
  - `ld_ready` = 1, decoded from state
- Read latency is 1 cycle: an address presented before edge t gives data valid after edge t. The output holds until the next edge.
- Write latency is 1 cycle: a write at edge t is readable by an access sampled at edge t+1.
- Loader throughput is 1 beat/cycle; back-to-back beats need no bubbles.
- Last-beat timing: the last beat is accepted at edge t.
  - `mem_ready` = 1 and `ld_ready` = 0 after edge t.
  - The first port A read is sampled at edge t+1.
- Reset mid-LOAD or mid-RUN:
  - Outputs clear immediately, without waiting for the clock.
  - A loader beat in flight in that cycle is not written.
  - After `rst_in` rises, the host must reload; at minimum a single `ld_last` beat is needed to re-enter RUN.
- Error flag timing: `addr_err` rises at the edge that samples the out-of-range access. For that cycle the read output is 0.
- Both ports access every cycle in RUN; there is no backpressure toward the VPU.

## Test plan
- Basic load and first read:
  - Stimulus: reset, then load 0x13, 0x00, 0x00, 0x00 at 0..3 with `ld_last` on beat 4.
  - Response: `ld_ready` = 0 and `mem_ready` = 1 the cycle after beat 4. Then `addr_a` = 0 gives `data_a` = 0x13 one cycle later; `addr_a` = 3 gives 0x00.
- Port B ignored during LOAD:
  - Stimulus: in LOAD, drive `we_b` = 1, `addr_b` = 5, `src_b` = 0xAA, and load 0x77 at 5 (last).
  - Response: in RUN, `addr_b` = 5 with `we_b` = 0 gives `data_b` = 0x77. `data_b` stays 0 throughout LOAD.
- Read-first collision:
  - Setup: `mem[0x10]` = 0x11.
  - Stimulus: same cycle, `addr_a` = 0x10 and port B writes 0x55 to 0x10.
  - Response: `data_a` = 0x11 and `data_b` = 0x55. The next cycle, `addr_a` = 0x10 gives `data_a` = 0x55.
- Out-of-range write:
  - Stimulus: in RUN, `we_b` = 1, `addr_b` = 0x0001_0000, `src_b` = 0xEE.
  - Response: `addr_err` = 1 from the next cycle and stays 1; `data_b` = 0. A read of `mem[0]` is unchanged.
- Asynchronous reset mid-RUN:
  - Stimulus: assert `rst_in` = 0 between clock edges.
  - Response:
    - `mem_ready`, `data_a` and `addr_err` go to 0 immediately and `ld_ready` goes to 1.
    - After release, a single `ld_last` beat writing 0x99 to 0x20 returns to RUN.
    - Address 0x0 still reads 0x13, showing the contents were retained.
- Back-to-back loader throughput:
  - Stimulus: load 256 consecutive beats with `ld_valid` held high for 256 cycles.
  - Response: every beat is accepted in consecutive cycles, and a port A sweep of the 256 addresses in RUN returns the loaded pattern.

Source files
------------

// File: rtl/vpu_ram_if.sv
// vpu_ram_if: bundles the VPU port A/B memory bus and the host loader stream
// for vpu_ram.
//   master : VPU/loader side. Drives addresses, write data and loader beats.
//            Receives read data, ld_ready, mem_ready and addr_err.
//   slave  : memory side (vpu_ram).
interface vpu_ram_if #(
    parameter int unsigned ADDR_WID = 16,
    parameter int unsigned DATA_WID = 8
);
    logic [31:0]         addr_a;
    logic [DATA_WID-1:0] data_a;
    logic [31:0]         addr_b;
    logic                we_b;
    logic [DATA_WID-1:0] src_b;
    logic [DATA_WID-1:0] data_b;
    logic                ld_valid;
    logic                ld_ready;
    logic [ADDR_WID-1:0] ld_addr;
    logic [DATA_WID-1:0] ld_data;
    logic                ld_last;
    logic                mem_ready;
    logic                addr_err;

    modport master (
        output addr_a, addr_b, we_b, src_b,
        output ld_valid, ld_addr, ld_data, ld_last,
        input  data_a, data_b, ld_ready, mem_ready, addr_err
    );

    modport slave (
        input  addr_a, addr_b, we_b, src_b,
        input  ld_valid, ld_addr, ld_data, ld_last,
        output data_a, data_b, ld_ready, mem_ready, addr_err
    );
endinterface

// File: rtl/vpu_ram.sv
// vpu_ram: dual-port byte memory behind the VPU. Port A is read-only and
// port B is read/write. Both ports have one-cycle read latency. After reset
// the block is in LOAD and accepts a program image from the host loader. The
// final beat moves it to RUN and raises mem_ready.
// Ports:
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-low reset (state/outputs only, not the array)
//   bus    : vpu_ram_if.slave, carrying port A/B, the loader stream and status
module vpu_ram #(
    parameter int unsigned ADDR_WID = 16,
    parameter int unsigned DATA_WID = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    vpu_ram_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WID;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [DATA_WID-1:0] r_mem [DEPTH];
    logic [DATA_WID-1:0] r_data_a;
    logic [DATA_WID-1:0] r_data_b;
    logic                r_mem_ready;
    logic                r_addr_err;

    logic                w_run;
    logic                w_a_in;
    logic                w_b_in;
    logic                w_we;
    logic [ADDR_WID-1:0] w_waddr;
    logic [DATA_WID-1:0] w_wdata;
    logic [DATA_WID-1:0] w_rd_a;
    logic [DATA_WID-1:0] w_rd_b;

    // Address decode: upper bits must be zero to hit the implemented array
    assign w_run  = (r_state == ST_RUN);
    assign w_a_in = (bus.addr_a[31:ADDR_WID] == '0);
    assign w_b_in = (bus.addr_b[31:ADDR_WID] == '0);

    // Single write port, shared by the loader (LOAD) and port B (RUN).
    // A beat presented while reset is held must not land in the array.
    assign w_we    = rst_in &&
                     (w_run ? (bus.we_b && w_b_in) : bus.ld_valid);
    assign w_waddr = w_run ? bus.addr_b[ADDR_WID-1:0] : bus.ld_addr;
    assign w_wdata = w_run ? bus.src_b : bus.ld_data;

    assign w_rd_a = r_mem[bus.addr_a[ADDR_WID-1:0]];
    assign w_rd_b = r_mem[bus.addr_b[ADDR_WID-1:0]];

    // Array: no reset, so contents survive rst_in and the array maps to block RAM
    always_ff @(posedge clk_in) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Control FSM with registered read data and status.
    // Reads sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ST_LOAD;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_mem_ready <= 1'b0;
            r_addr_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_data_a <= '0;
                    r_data_b <= '0;
                    if (bus.ld_valid && bus.ld_last) begin
                        r_state     <= ST_RUN;
                        r_mem_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_data_a <= w_a_in ? w_rd_a : '0;
                    if (!w_b_in) begin
                        r_data_b <= '0;
                    end else if (bus.we_b) begin
                        r_data_b <= bus.src_b;
                    end else begin
                        r_data_b <= w_rd_b;
                    end
                    if (!w_a_in || !w_b_in) begin
                        r_addr_err <= 1'b1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign bus.data_a    = r_data_a;
    assign bus.data_b    = r_data_b;
    assign bus.mem_ready = r_mem_ready;
    assign bus.addr_err  = r_addr_err;
    assign bus.ld_ready  = (r_state == ST_LOAD);
endmodule

// File: tb/tb_vpu_ram.sv
// tb_vpu_ram: directed self-checking bench for vpu_ram. It covers the load
// phase, RUN reads and writes, read-first collisions, out-of-range handling,
// asynchronous reset with retained contents, and back-to-back loading.
module tb_vpu_ram;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    vpu_ram_if #(.ADDR_WID(16), .DATA_WID(8)) bus ();

    vpu_ram #(.ADDR_WID(16), .DATA_WID(8)) u_dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_tests++; if (bus.data_a !== 8'h00) begin n_fail++; $display("FAIL rst_data_a got %h exp 00", bus.data_a); end
        n_tests++; if (bus.data_b !== 8'h00) begin n_fail++; $display("FAIL rst_data_b got %h exp 00", bus.data_b); end
        n_tests++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready got %b exp 0", bus.mem_ready); end
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL rst_addr_err got %b exp 0", bus.addr_err); end
        n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ld_ready got %b exp 1", bus.ld_ready); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_load_basic();
        logic [7:0] vals [4];
        vals = '{8'h13, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 16'(i);
            bus.ld_data  = vals[i];
            bus.ld_last  = (i == 3);
            n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ld_ready beat %0d got %b exp 1", i, bus.ld_ready); end
            step();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        n_tests++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ld_ready_run got %b exp 0", bus.ld_ready); end
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL basic_mem_ready got %b exp 1", bus.mem_ready); end
        bus.addr_a = 32'h0;
        step();
        n_tests++; if (bus.data_a !== 8'h13) begin n_fail++; $display("FAIL basic_read0 got %h exp 13", bus.data_a); end
        bus.addr_a = 32'h3;
        step();
        n_tests++; if (bus.data_a !== 8'h00) begin n_fail++; $display("FAIL basic_read3 got %h exp 00", bus.data_a); end
    endtask

    task automatic test_port_b_ignored();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.addr_a = 32'h0;
        bus.we_b   = 1'b1;
        bus.addr_b = 32'h5;
        bus.src_b  = 8'hAA;
        // A plain idle cycle in LOAD with port B writing
        step();
        n_tests++; if (bus.data_b !== 8'h00) begin n_fail++; $display("FAIL pb_load_data_b got %h exp 00", bus.data_b); end
        n_tests++; if (bus.data_a !== 8'h00) begin n_fail++; $display("FAIL pb_load_data_a got %h exp 00", bus.data_a); end
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 16'h5;
        bus.ld_data  = 8'h77;
        bus.ld_last  = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.we_b     = 1'b0;
        n_tests++; if (bus.data_b !== 8'h00) begin n_fail++; $display("FAIL pb_last_data_b got %h exp 00", bus.data_b); end
        step();
        n_tests++; if (bus.data_b !== 8'h77) begin n_fail++; $display("FAIL pb_run_read5 got %h exp 77", bus.data_b); end
        n_tests++; if (bus.data_a !== 8'h13) begin n_fail++; $display("FAIL pb_retained0 got %h exp 13", bus.data_a); end
    endtask

    task automatic test_collision();
        bus.we_b   = 1'b1;
        bus.addr_b = 32'h10;
        bus.src_b  = 8'h11;
        step();
        n_tests++; if (bus.data_b !== 8'h11) begin n_fail++; $display("FAIL col_setup_wt got %h exp 11", bus.data_b); end
        bus.addr_a = 32'h10;
        bus.src_b  = 8'h55;
        step();
        n_tests++; if (bus.data_a !== 8'h11) begin n_fail++; $display("FAIL col_read_first got %h exp 11", bus.data_a); end
        n_tests++; if (bus.data_b !== 8'h55) begin n_fail++; $display("FAIL col_write_through got %h exp 55", bus.data_b); end
        bus.we_b = 1'b0;
        step();
        n_tests++; if (bus.data_a !== 8'h55) begin n_fail++; $display("FAIL col_new_value got %h exp 55", bus.data_a); end
    endtask

    task automatic test_out_of_range();
        bus.addr_a = 32'h0;
        bus.we_b   = 1'b1;
        bus.addr_b = 32'h0001_0000;
        bus.src_b  = 8'hEE;
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_before got %b exp 0", bus.addr_err); end
        step();
        bus.we_b = 1'b0;
        bus.addr_b = 32'h0;
        n_tests++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_set got %b exp 1", bus.addr_err); end
        n_tests++; if (bus.data_b !== 8'h00) begin n_fail++; $display("FAIL oor_data_b got %h exp 00", bus.data_b); end
        // Loader beats in RUN must be ignored
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 16'h0;
        bus.ld_data  = 8'hFF;
        bus.ld_last  = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        n_tests++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_err_sticky got %b exp 1", bus.addr_err); end
        n_tests++; if (bus.data_b !== 8'h13) begin n_fail++; $display("FAIL oor_mem0_b got %h exp 13", bus.data_b); end
        step();
        n_tests++; if (bus.data_a !== 8'h13) begin n_fail++; $display("FAIL oor_mem0_a got %h exp 13", bus.data_a); end
        // Out-of-range read on port A returns 0
        bus.addr_a = 32'h8000_0000;
        step();
        n_tests++; if (bus.data_a !== 8'h00) begin n_fail++; $display("FAIL oor_read_a got %h exp 00", bus.data_a); end
    endtask

    task automatic test_reset_mid_run();
        bus.we_b   = 1'b1;
        bus.addr_b = 32'h30;
        bus.src_b  = 8'h31;
        step();
        bus.we_b   = 1'b0;
        bus.addr_a = 32'h0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.data_a !== 8'h00) begin n_fail++; $display("FAIL mid_data_a got %h exp 00", bus.data_a); end
        n_tests++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_mem_ready got %b exp 0", bus.mem_ready); end
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL mid_addr_err got %b exp 0", bus.addr_err); end
        n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ld_ready got %b exp 1", bus.ld_ready); end
        // Beat in flight while reset is held must not be written
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 16'h30;
        bus.ld_data  = 8'h42;
        bus.ld_last  = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        n_tests++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL mid_held_mem_ready got %b exp 0", bus.mem_ready); end
        rst_n = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 16'h20;
        bus.ld_data  = 8'h99;
        bus.ld_last  = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rerun got %b exp 1", bus.mem_ready); end
        bus.addr_a = 32'h0;
        step();
        n_tests++; if (bus.data_a !== 8'h13) begin n_fail++; $display("FAIL mid_retained0 got %h exp 13", bus.data_a); end
        bus.addr_a = 32'h20;
        step();
        n_tests++; if (bus.data_a !== 8'h99) begin n_fail++; $display("FAIL mid_read20 got %h exp 99", bus.data_a); end
        bus.addr_a = 32'h30;
        step();
        n_tests++; if (bus.data_a !== 8'h31) begin n_fail++; $display("FAIL mid_inflight_dropped got %h exp 31", bus.data_a); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = 16'(16'h0100 + i);
            bus.ld_data  = 8'(i) ^ 8'h5A;
            bus.ld_last  = (i == 255);
            n_tests++; if (bus.ld_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ld_ready beat %0d got %b exp 1", i, bus.ld_ready); end
            step();
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        n_tests++; if (bus.mem_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_mem_ready got %b exp 1", bus.mem_ready); end
        for (int i = 0; i < 256; i++) begin
            bus.addr_a = 32'(32'h0100 + i);
            step();
            exp_v = 8'(i) ^ 8'h5A;
            n_tests++; if (bus.data_a !== exp_v) begin n_fail++; $display("FAIL b2b_sweep addr %0h got %h exp %h", 32'h100 + i, bus.data_a, exp_v); end
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.addr_a   = 32'h0;
        bus.addr_b   = 32'h0;
        bus.we_b     = 1'b0;
        bus.src_b    = 8'h0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 16'h0;
        bus.ld_data  = 8'h0;
        bus.ld_last  = 1'b0;

        test_reset();
        test_load_basic();
        test_port_b_ignored();
        test_collision();
        test_out_of_range();
        test_reset_mid_run();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
